// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures two operands on start, feeds one full-adder cell
// LSB first with a carry flop, and publishes {cout,sum} at completion.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, shadow;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_sum, fa_carry;
  logic             last;
  logic             accept;

  // Full-adder cell on the current LSBs and the fed-back carry
  assign fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // Terminal count only matters while RUN is active
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state == IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: DONE always returns to IDLE, so requests there are dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: operand capture, bit-serial shifting, and result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      shadow <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      shadow <= '0;
      cnt    <= '0;
      carry  <= cin;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      shadow <= {fa_sum, shadow[WIDTH-1:1]};
      carry  <= fa_carry;
      cnt    <= cnt + CW'(1);
      // The final bit goes straight into sum so no partial word is ever visible
      if (last) begin
        sum  <= {fa_sum, shadow[WIDTH-1:1]};
        cout <= fa_carry;
      end
    end
  end

endmodule
